serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor: computes diff = a - b - borrow_in, one bit per clock, LSB first.
- Wraps a single one-bit full-subtractor cell; a borrow flip-flop carries the cell's borrow output back into its borrow input on the next cycle.
- Sits directly upstream of the one-bit full subtractor: it sequences operands into the cell and consumes its D/B_out each cycle.
- Used as the multi-bit datapath stage in area-constrained designs.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_fs_cell.sv | 22 ++
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared types and constants for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE, SHIFT, DONE).
//   DEFAULT_WIDTH : default operand/result width.
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_pkg

// File: rtl/serial_fs_cell.sv
// ---------------------------------------------------------------------------
// serial_fs_cell
//   Purely combinational one-bit full subtractor: a - b - bin.
//   Ports:
//     a_i    : minuend bit
//     b_i    : subtrahend bit
//     bin_i  : borrow in
//     d_o    : difference bit
//     bout_o : borrow out
// ---------------------------------------------------------------------------
module serial_fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : serial_fs_cell

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b - borrow_in (mod 2^WIDTH),
//   one bit per clock, LSB first, through a single serial_fs_cell with a
//   borrow flip-flop feeding the cell's borrow back on the next cycle.
//   Optional macro SERIAL_SUBTRACTOR_OVF_EN adds the ovf output
//   (two's-complement overflow flag).
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : asynchronous active-low reset
//     start      : request, sampled only in IDLE
//     a, b       : operands, captured on the accepted start
//     borrow_in  : initial borrow, captured on the accepted start
//     busy       : high in SHIFT and DONE
//     done       : one-cycle pulse, result valid
//     diff       : registered difference, held until the next result
//     borrow_out : final borrow, held with diff
//     ovf        : signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             brw_q;
    logic             borrow_out_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are kept aside because the shift registers
    // lose them long before the result is complete.
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    serial_fs_cell u_cell (
        .a_i    (sh_a_q[0]),
        .b_i    (sh_b_q[0]),
        .bin_i  (brw_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // Result fills from the MSB side so after WIDTH shifts bit 0 is the LSB.
    assign res_d = {cell_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            brw_q        <= 1'b0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_a_q  <= a;
                        sh_b_q  <= b;
                        brw_q   <= borrow_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    res_q  <= res_d;
                    brw_q  <= cell_bout;
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        // Publish the final bit's results on the edge that
                        // enters DONE, so they are valid alongside done.
                        diff_q       <= res_d;
                        borrow_out_q <= cell_bout;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        ovf_q <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
//   queued at issue time; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf;
`endif

    exp_t       exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] prev_diff = 8'h00;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL done_unexpected: got done=1 expected no result at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow_out", 32'(borrow_out), 32'(e.bo));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after
    // the DONE->IDLE edge. Checks busy/done timing and diff hold while shifting.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                          input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        e.d = ed; e.bo = eb; e.ov = eo;
        exp_q.push_back(e);
        a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_v; borrow_in = ~tbin;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            check("busy_timing", 32'(busy), 32'(k <= 8));
            check("done_timing", 32'(done), 32'(k == 8));
            if (k < 8) check("diff_hold", 32'(diff), 32'(prev_diff));
        end
        prev_diff = ed;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Starts during SHIFT and during DONE must be ignored.
        begin
            exp_t e;
            e.d = 8'h06; e.bo = 1'b0; e.ov = 1'b0;
            exp_q.push_back(e);
        end
        a = 8'h0A; b = 8'h04; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);                     // E0
        @(negedge clk); start = 1'b0;
        @(negedge clk);                     // after E1
        @(negedge clk);                     // after E2
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk); start = 1'b0;       // after E3
        check("busy_shift", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);          // after E8: DONE
        check("done_first", 32'(done), 32'd1);
        start = 1'b1; a = 8'hFF; b = 8'h00;
        @(negedge clk);                     // after E9: IDLE
        check("ignored_in_done_busy", 32'(busy), 32'd0);
        check("ignored_in_done_done", 32'(done), 32'd0);
        a = 8'h10; b = 8'h01;
        begin
            exp_t e;
            e.d = 8'h0F; e.bo = 1'b0; e.ov = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);                     // after E10: accepted
        start = 1'b0;
        check("accept_e10", 32'(busy), 32'd1);
        repeat (9) @(negedge clk);
        check("back_idle", 32'(busy), 32'd0);
        prev_diff = 8'h0F;

        // Asynchronous reset mid-operation discards the partial result.
        a = 8'h55; b = 8'h22; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        prev_diff = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_serial_subtractor
